rotate_seq_ctrl: RTL and testbench
==================================

// Module: rotate_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the ALU shift/rotate path. Accepts one op (ROR, ROL, SHR, SHRA, SHL)
//  over a valid/ready request channel, steps operand 1 bit/cycle through a shared single-step
//  shifter, returns result on a valid/ready response channel. Replaces the 32-way barrel mux in
//  area-constrained builds; sits between control unit and ALU result mux (feeds Z register path).
// PARAMETERS
//  WIDTH    32  datapath width in bits
//  SHW      5   shift-amount width in bits (log2 WIDTH)
// PORTS
//  clock      in   1      system clock, all state on rising edge
//  clear_n    in   1      asynchronous, active-low reset
//  req_valid  in   1      request present
//  req_ready  out  1      controller can accept (IDLE only)
//  req_op     in   3      000 ROR, 001 ROL, 010 SHR, 011 SHRA, 100 SHL, 101-111 illegal
//  req_data   in   WIDTH  operand
//  req_shamt  in   SHW    shift/rotate amount, 0..WIDTH-1
//  flush      in   1      synchronous abort, returns to IDLE, drops op
//  res_valid  out  1      result held valid (DONE only)
//  res_ready  in   1      consumer takes result
//  res_data   out  WIDTH  result
//  res_err    out  1      1 = illegal op; res_data = operand unchanged
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  - Reset (clear_n=0, async): state IDLE, count 0, res_data 0, res_err 0, res_valid 0, busy 0,
//    req_ready 1 once clear_n deasserts. Reset mid-op discards op; no partial result emitted.
//  - FSM IDLE/BUSY/DONE. req_ready = (state==IDLE). res_valid = (state==DONE).
//  - IDLE: on req_valid, latch operand into working reg, op, count=req_shamt; res_err=op illegal.
//    Illegal op or shamt=0 -> DONE; else -> BUSY.
//  - BUSY: per edge apply one step, count--; on edge where count==1 -> DONE.
//  - Step: ROR {w[0],w[W-1:1]}; ROL {w[W-2:0],w[W-1]}; SHR {0,w[W-1:1]};
//    SHRA {w[W-1],w[W-1:1]}; SHL {w[W-2:0],0}.
//  - Latency: res_valid high shamt+1 cycles after accepting edge; throughput 1 op per shamt+2 cycles.
//  - DONE: res_data/res_err stable while res_valid && !res_ready; on res_ready -> IDLE.
//    No request accepted in DONE (req_ready=0 even if res_ready=1 same cycle).
//  - flush: wins over all other events in any state; next state IDLE, res_valid drops next
//    cycle, res_data retains last value. flush with req_valid in IDLE: request not accepted.
//  - req_* inputs ignored outside IDLE; may change freely while busy.
//  - res_data only updated at accept/step edges; never X after reset.
// STRUCTURE
//  - Shared package rot_pkg: op encodings (OP_ROR..OP_SHL), state encoding, WIDTH default.
//  - One sub-module: rot_step (combinational single-bit step, inputs op + word, output word),
//    reused by datapath verification as the step reference.
//  - Controller: FSM, down-counter, working register, handshake logic.
// TESTING
//  1 ROR data 0x00000001 shamt 1 -> res_data 0x80000000, res_valid 2 cycles after accept.
//  2 SHRA data 0x80000000 shamt 31 -> 0xFFFFFFFF, err 0; SHR same -> 0x00000001; latency 32.
//  3 ROL 0x12345678 shamt 0 -> 0x12345678 after 1 cycle; op 3'b110 -> res_err 1, data unchanged.
//  4 Backpressure: res_ready low 5 cycles -> res_data stable, req_ready 0; new req_valid ignored
//    until IDLE.
//  5 flush at count 10 of SHL 0x1 shamt 20 -> IDLE next cycle, no res_valid; next op correct.
//  6 clear_n pulsed mid-BUSY (between edges) -> outputs reset immediately; random ops vs model.

Source files
------------

// File: rtl/rotate_seq_ctrl_pkg.sv
// Shared encodings for the sequential shift/rotate controller: op codes, FSM states and the
// default datapath geometry.
package rot_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_SHW   = 5;

   localparam logic [2:0] OP_ROR  = 3'b000;
   localparam logic [2:0] OP_ROL  = 3'b001;
   localparam logic [2:0] OP_SHR  = 3'b010;
   localparam logic [2:0] OP_SHRA = 3'b011;
   localparam logic [2:0] OP_SHL  = 3'b100;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Codes 101..111 are reserved and reported back as errors.
   function automatic logic op_illegal(input logic [2:0] op);
      return (op > OP_SHL);
   endfunction

endpackage

// File: rtl/rotate_seq_ctrl_if.sv
// Request/response channel bundle between the control unit (master) and the shift sequencer
// (slave), including the abort and status lines.
interface rotate_seq_ctrl_if
   import rot_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SHW   = DEF_SHW
);

   logic             req_valid;
   logic             req_ready;
   logic [2:0]       req_op;
   logic [WIDTH-1:0] req_data;
   logic [SHW-1:0]   req_shamt;
   logic             flush;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;
   logic             res_err;
   logic             busy;

   modport master (
      output req_valid, req_op, req_data, req_shamt, flush, res_ready,
      input  req_ready, res_valid, res_data, res_err, busy
   );

   modport slave (
      input  req_valid, req_op, req_data, req_shamt, flush, res_ready,
      output req_ready, res_valid, res_data, res_err, busy
   );

endinterface

// File: rtl/rotate_seq_ctrl_step.sv
// Single-bit shift/rotate step; the controller applies it once per busy cycle and datapath
// checks reuse it as the step reference.
module rot_step
   import rot_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_word,
   output logic [WIDTH-1:0] o_word
);

   // Reserved op codes pass the word through so an illegal op can never corrupt the operand.
   always_comb begin
      o_word = i_word;
      case (i_op)
         OP_ROR:  o_word = {i_word[0], i_word[WIDTH-1:1]};
         OP_ROL:  o_word = {i_word[WIDTH-2:0], i_word[WIDTH-1]};
         OP_SHR:  o_word = {1'b0, i_word[WIDTH-1:1]};
         OP_SHRA: o_word = {i_word[WIDTH-1], i_word[WIDTH-1:1]};
         OP_SHL:  o_word = {i_word[WIDTH-2:0], 1'b0};
         default: o_word = i_word;
      endcase
   end

endmodule

// File: rtl/rotate_seq_ctrl.sv
// Multi-cycle shift/rotate sequencer: accepts one op, steps the operand one bit per cycle
// through rot_step, and holds the result on the response channel until taken.
module rotate_seq_ctrl
   import rot_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SHW   = DEF_SHW
) (
   input logic              clock,
   input logic              clear_n,
   rotate_seq_ctrl_if.slave bus
);

   logic [1:0]       r_state;
   logic [SHW-1:0]   r_count;
   logic [WIDTH-1:0] r_work;
   logic [2:0]       r_op;
   logic             r_err;
   logic [WIDTH-1:0] w_step;
   logic             w_illegal;

   assign w_illegal = op_illegal(bus.req_op);

   rot_step #(.WIDTH(WIDTH)) u_step (
      .i_op   (r_op),
      .i_word (r_work),
      .o_word (w_step)
   );

   // The working register doubles as the result register, so it only moves on accept or step
   // edges and keeps its last value across flush.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         r_state <= ST_IDLE;
         r_count <= '0;
         r_work  <= '0;
         r_op    <= OP_ROR;
         r_err   <= 1'b0;
      end else if (bus.flush) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  r_work  <= bus.req_data;
                  r_op    <= bus.req_op;
                  r_count <= bus.req_shamt;
                  r_err   <= w_illegal;
                  r_state <= (w_illegal || bus.req_shamt == '0) ? ST_DONE : ST_BUSY;
               end
            end
            ST_BUSY: begin
               r_work  <= w_step;
               r_count <= r_count - SHW'(1);
               if (r_count == SHW'(1)) begin
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (bus.res_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready = (r_state == ST_IDLE);
   assign bus.res_valid = (r_state == ST_DONE);
   assign bus.busy      = (r_state != ST_IDLE);
   assign bus.res_data  = r_work;
   assign bus.res_err   = r_err;

endmodule

// File: tb/tb_rotate_seq_ctrl.sv
// Self-checking bench for rotate_seq_ctrl: vector table, hand-written flush/reset sequences and
// random ops against a closed-form reference, all results routed through a scoreboard queue.
module tb_rotate_seq_ctrl;
   import rot_pkg::*;

   localparam int W = 32;
   localparam int S = 5;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] data;
      logic [S-1:0] shamt;
      logic [W-1:0] expData;
      logic         expErr;
      int           resDelay;
   } vecT;

   typedef struct {
      logic [W-1:0] data;
      logic         err;
   } expT;

   logic clock;
   logic clear_n;
   int   checks;
   int   errors;
   expT  sbQ[$];
   vecT  vecs[12];

   rotate_seq_ctrl_if #(.WIDTH(W), .SHW(S)) bus ();

   rotate_seq_ctrl #(.WIDTH(W), .SHW(S)) dut (
      .clock   (clock),
      .clear_n (clear_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
      end
   endtask

   // Closed-form reference, deliberately not built from single-bit steps.
   function automatic logic [W-1:0] refOp(input logic [2:0] op, input logic [W-1:0] d,
                                          input logic [S-1:0] s);
      int n;
      n = int'(s);
      case (op)
         OP_ROR:  return (n == 0) ? d : ((d >> n) | (d << (W - n)));
         OP_ROL:  return (n == 0) ? d : ((d << n) | (d >> (W - n)));
         OP_SHR:  return d >> n;
         OP_SHRA: return W'($signed(d) >>> n);
         OP_SHL:  return d << n;
         default: return d;
      endcase
   endfunction

   // One full transaction: accept, latency count, optional backpressure, scoreboard compare.
   task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] data,
                                input logic [S-1:0] shamt, input logic [W-1:0] expData,
                                input logic expErr, input int resDelay);
      int           lat;
      int           expLat;
      logic [W-1:0] held;
      expT          e;
      checkOutput("acceptReady", bus.req_ready, 1);
      sbQ.push_back('{data: expData, err: expErr});
      expLat = (expErr || shamt == '0) ? 1 : int'(shamt) + 1;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_data  = data;
      bus.req_shamt = shamt;
      @(posedge clock); #1;
      bus.req_valid = 1'b0;
      bus.req_op    = 3'($urandom);
      bus.req_data  = $urandom;
      bus.req_shamt = S'($urandom);
      lat = 1;
      while (!bus.res_valid && lat < 100) begin
         @(posedge clock); #1;
         lat++;
      end
      checkOutput("latency", lat, expLat);
      held = bus.res_data;
      for (int i = 0; i < resDelay; i++) begin
         bus.req_valid = 1'b1;
         bus.req_op    = OP_ROR;
         bus.req_data  = $urandom;
         @(posedge clock); #1;
         checkOutput("holdData", bus.res_data, held);
         checkOutput("holdValid", bus.res_valid, 1);
         checkOutput("holdReqReady", bus.req_ready, 0);
      end
      bus.res_ready = 1'b1;
      if (resDelay > 0) checkOutput("doneReqReady", bus.req_ready, 0);
      if (sbQ.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL sbUnderflow: got empty queue, wanted an entry");
      end else begin
         e = sbQ.pop_front();
         checkOutput("resData", bus.res_data, e.data);
         checkOutput("resErr", bus.res_err, e.err);
      end
      @(posedge clock); #1;
      bus.res_ready = 1'b0;
      bus.req_valid = 1'b0;
      checkOutput("postValid", bus.res_valid, 0);
      checkOutput("postBusy", bus.busy, 0);
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      clear_n        = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_op     = OP_ROR;
      bus.req_data   = '0;
      bus.req_shamt  = '0;
      bus.flush      = 1'b0;
      bus.res_ready  = 1'b0;

      vecs[0]  = '{OP_ROR,  32'h0000_0001, 5'd1,  32'h8000_0000, 1'b0, 0};
      vecs[1]  = '{OP_SHRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 0};
      vecs[2]  = '{OP_SHR,  32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 1};
      vecs[3]  = '{OP_ROL,  32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, 5};
      vecs[4]  = '{3'b110,  32'hDEAD_BEEF, 5'd7,  32'hDEAD_BEEF, 1'b1, 0};
      vecs[5]  = '{OP_SHL,  32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 0};
      vecs[6]  = '{OP_ROL,  32'h8000_0001, 5'd4,  32'h0000_0018, 1'b0, 2};
      vecs[7]  = '{OP_SHRA, 32'h7FFF_FFFF, 5'd4,  32'h07FF_FFFF, 1'b0, 0};
      vecs[8]  = '{OP_ROR,  32'h1234_5678, 5'd8,  32'h7812_3456, 1'b0, 0};
      vecs[9]  = '{3'b111,  32'h0F0F_0F0F, 5'd0,  32'h0F0F_0F0F, 1'b1, 0};
      vecs[10] = '{OP_SHL,  32'hFFFF_FFFF, 5'd16, 32'hFFFF_0000, 1'b0, 0};
      vecs[11] = '{OP_SHR,  32'hF000_0000, 5'd28, 32'h0000_000F, 1'b0, 3};

      repeat (2) @(posedge clock);
      #1;
      checkOutput("rstValid", bus.res_valid, 0);
      checkOutput("rstBusy", bus.busy, 0);
      checkOutput("rstData", bus.res_data, 0);
      checkOutput("rstErr", bus.res_err, 0);
      @(negedge clock) clear_n = 1'b1;
      @(posedge clock); #1;
      checkOutput("rstReqReady", bus.req_ready, 1);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].op, vecs[i].data, vecs[i].shamt, vecs[i].expData,
                       vecs[i].expErr, vecs[i].resDelay);
      end

      // Flush mid-op with 10 steps remaining: partial word stays visible, no response.
      bus.req_valid = 1'b1;
      bus.req_op    = OP_SHL;
      bus.req_data  = 32'h0000_0001;
      bus.req_shamt = 5'd20;
      @(posedge clock); #1;
      bus.req_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clock); #1;
         checkOutput("flushPreValid", bus.res_valid, 0);
      end
      bus.flush = 1'b1;
      @(posedge clock); #1;
      bus.flush = 1'b0;
      checkOutput("flushBusy", bus.busy, 0);
      checkOutput("flushValid", bus.res_valid, 0);
      checkOutput("flushData", bus.res_data, 32'h0000_0400);
      checkOutput("flushReqReady", bus.req_ready, 1);

      bus.req_valid = 1'b1;
      bus.flush     = 1'b1;
      bus.req_op    = OP_ROR;
      bus.req_shamt = 5'd0;
      @(posedge clock); #1;
      bus.req_valid = 1'b0;
      bus.flush     = 1'b0;
      checkOutput("flushReqBusy", bus.busy, 0);
      checkOutput("flushReqValid", bus.res_valid, 0);
      applyStimulus(OP_SHL, 32'h0000_0003, 5'd5, 32'h0000_0060, 1'b0, 0);

      // Asynchronous reset between edges while busy.
      bus.req_valid = 1'b1;
      bus.req_op    = OP_SHL;
      bus.req_data  = 32'h0000_0001;
      bus.req_shamt = 5'd20;
      @(posedge clock); #1;
      bus.req_valid = 1'b0;
      repeat (3) @(posedge clock);
      #3;
      clear_n = 1'b0;
      #1;
      checkOutput("midRstBusy", bus.busy, 0);
      checkOutput("midRstData", bus.res_data, 0);
      checkOutput("midRstValid", bus.res_valid, 0);
      @(negedge clock) clear_n = 1'b1;
      @(posedge clock); #1;
      checkOutput("midRstReqReady", bus.req_ready, 1);

      for (int i = 0; i < 24; i++) begin
         logic [2:0]   rOp;
         logic [W-1:0] rData;
         logic [S-1:0] rShamt;
         rOp    = 3'($urandom_range(0, 7));
         rData  = $urandom;
         rShamt = S'($urandom_range(0, 31));
         applyStimulus(rOp, rData, rShamt, refOp(rOp, rData, rShamt), op_illegal(rOp),
                       int'($urandom_range(0, 2)));
      end

      checkOutput("sbDrained", sbQ.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
